// File: rtl/pe_array_ws_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pe_array_ws_if : control, weight, activation and result bundle for       |
// |                  the weight-stationary PE array                          |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
interface pe_array_ws_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);
  logic                     gate;
  logic                     w_load;
  logic [COLS*DATA_W-1:0]   w_in;
  logic [ROWS*DATA_W-1:0]   act_in;
  logic                     act_valid;
  logic [COLS*ACC_W-1:0]    psum_out;
  logic                     psum_valid;
  logic [COLS-1:0]          flag_overflow_O;
  logic                     busy;

  modport master (
    output gate, w_load, w_in, act_in, act_valid,
    input  psum_out, psum_valid, flag_overflow_O, busy
  );

  modport slave (
    input  gate, w_load, w_in, act_in, act_valid,
    output psum_out, psum_valid, flag_overflow_O, busy
  );
endinterface
`default_nettype wire

// File: rtl/pe_array_ws.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pe_array_ws : ROWS x COLS weight-stationary systolic MAC array with      |
// |               input skew, output deskew, valid pipeline, overflow flags  |
// | Option      : PE_ARRAY_SAT_EN selects saturating accumulation            |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module pe_array_ws #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input logic          clk,
  input logic          rstn,
  pe_array_ws_if.slave bus
);
  localparam int c_lat = ROWS + COLS - 1;
`ifdef PE_ARRAY_SAT_EN
  localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  logic signed [DATA_W-1:0] r_w [ROWS][COLS];
  logic [c_lat-1:0]         r_vld;
  logic [COLS*ACC_W-1:0]    r_psum_out;
  logic [COLS-1:0]          r_flag;
  logic                     r_psum_valid;

  logic                     w_busy;
  logic                     w_load_acc;
  logic                     w_act_acc;
  logic signed [DATA_W-1:0] w_lane   [ROWS];
  logic signed [DATA_W-1:0] w_row_in [ROWS];
  logic signed [DATA_W-1:0] w_act    [ROWS][COLS];
  logic signed [ACC_W-1:0]  w_sum    [ROWS][COLS];
  logic                     w_ovf    [ROWS][COLS];
  logic signed [ACC_W-1:0]  w_bot_sum [COLS];
  logic                     w_bot_ovf [COLS];

  // Weights may only move while the pipeline is empty, and a load steals the cycle.
  assign w_busy     = |r_vld;
  assign w_load_acc = bus.gate & bus.w_load & ~w_busy;
  assign w_act_acc  = bus.gate & bus.act_valid & ~w_load_acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_w[r][c] <= '0;
    end else if (w_load_acc) begin
      for (int c = 0; c < COLS; c++) begin
        r_w[0][c] <= bus.w_in[c*DATA_W +: DATA_W];
        for (int r = 1; r < ROWS; r++)
          r_w[r][c] <= r_w[r-1][c];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_vld <= '0;
    else if (bus.gate)
      r_vld <= (r_vld << 1) | c_lat'(w_act_acc);
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign w_lane[r] = w_act_acc ? bus.act_in[r*DATA_W +: DATA_W] : '0;

    if (r == 0) begin : g_noskew
      assign w_row_in[r] = w_lane[r];
    end else begin : g_skew
      logic signed [DATA_W-1:0] r_sk [r];
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < r; i++) r_sk[i] <= '0;
        end else if (bus.gate) begin
          r_sk[0] <= w_lane[r];
          for (int i = 1; i < r; i++) r_sk[i] <= r_sk[i-1];
        end
      end
      assign w_row_in[r] = r_sk[r-1];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [DATA_W-1:0]   w_a;
      logic signed [2*DATA_W-1:0] w_prod;
      logic signed [ACC_W-1:0]    w_p;
      logic signed [ACC_W-1:0]    w_pin;
      logic signed [ACC_W-1:0]    w_add;
      logic signed [ACC_W-1:0]    w_next;
      logic                       w_oin;
      logic                       w_add_ovf;
      logic signed [DATA_W-1:0]   r_act;
      logic signed [ACC_W-1:0]    r_sum;
      logic                       r_ovf;

      if (c == 0) begin : g_a_edge
        assign w_a = w_row_in[r];
      end else begin : g_a_chain
        assign w_a = w_act[r][c-1];
      end

      if (r == 0) begin : g_top
        assign w_pin = '0;
        assign w_oin = 1'b0;
      end else begin : g_below
        assign w_pin = w_sum[r-1][c];
        assign w_oin = w_ovf[r-1][c];
      end

      assign w_prod    = (2*DATA_W)'(w_a) * (2*DATA_W)'(r_w[r][c]);
      assign w_p       = ACC_W'(w_prod);
      assign w_add     = w_pin + w_p;
      assign w_add_ovf = (w_pin[ACC_W-1] == w_p[ACC_W-1]) &&
                         (w_add[ACC_W-1] != w_pin[ACC_W-1]);
`ifdef PE_ARRAY_SAT_EN
      assign w_next = !w_add_ovf ? w_add : (w_pin[ACC_W-1] ? c_acc_min : c_acc_max);
`else
      assign w_next = w_add;
`endif

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_act <= '0;
          r_sum <= '0;
          r_ovf <= 1'b0;
        end else if (bus.gate) begin
          r_act <= w_a;
          r_sum <= w_next;
          r_ovf <= w_oin | w_add_ovf;
        end
      end

      assign w_act[r][c] = r_act;
      assign w_sum[r][c] = r_sum;
      assign w_ovf[r][c] = r_ovf;
    end
  end

  // Earlier columns finish sooner; delay them so a vector leaves in one cycle.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int c_depth = COLS - 1 - c;
    if (c_depth == 0) begin : g_direct
      assign w_bot_sum[c] = w_sum[ROWS-1][c];
      assign w_bot_ovf[c] = w_ovf[ROWS-1][c];
    end else begin : g_delay
      logic signed [ACC_W-1:0] r_ds [c_depth];
      logic [c_depth-1:0]      r_do;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < c_depth; i++) r_ds[i] <= '0;
          r_do <= '0;
        end else if (bus.gate) begin
          r_ds[0] <= w_sum[ROWS-1][c];
          for (int i = 1; i < c_depth; i++) r_ds[i] <= r_ds[i-1];
          r_do <= (r_do << 1) | c_depth'(w_ovf[ROWS-1][c]);
        end
      end
      assign w_bot_sum[c] = r_ds[c_depth-1];
      assign w_bot_ovf[c] = r_do[c_depth-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_psum_valid <= 1'b0;
      r_psum_out   <= '0;
      r_flag       <= '0;
    end else if (bus.gate) begin
      r_psum_valid <= r_vld[c_lat-1];
      for (int c = 0; c < COLS; c++) begin
        r_psum_out[c*ACC_W +: ACC_W] <= r_vld[c_lat-1] ? w_bot_sum[c] : '0;
        r_flag[c]                    <= r_vld[c_lat-1] & w_bot_ovf[c];
      end
    end
  end

  assign bus.psum_out        = r_psum_out;
  assign bus.psum_valid      = r_psum_valid;
  assign bus.flag_overflow_O = r_flag;
  assign bus.busy            = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_pe_array_ws.sv
`default_nettype none
// Directed, table-driven bench for pe_array_ws: a 4x4/32-bit array for function
// and timing, plus a 4x4/16-bit array for accumulator overflow behaviour.
module tb_pe_array_ws;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int ACC_S  = 16;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pe_array_ws_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();
  pe_array_ws_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_S)) bus_s ();

  pe_array_ws #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk (clk), .rstn(rstn), .bus (bus)
  );
  pe_array_ws #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_S)) dut_s (
    .clk (clk), .rstn(rstn), .bus (bus_s)
  );

  typedef struct packed {
    logic [ROWS-1:0][DATA_W-1:0] act;
    logic [COLS-1:0][ACC_W-1:0]  exp;
  } vec_t;

  vec_t                        tbl [8];
  logic [ROWS-1:0][DATA_W-1:0] a_v;
  logic [COLS-1:0][ACC_W-1:0]  e_ps;
  logic [COLS-1:0][DATA_W-1:0] w_v;
  logic [COLS-1:0][ACC_S-1:0]  e_s;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  function automatic logic [191:0] obs();
    return 192'({bus.psum_valid, bus.flag_overflow_O, bus.psum_out});
  endfunction

  function automatic logic [191:0] expv(input logic v, input logic [3:0] f, input logic [127:0] p);
    return 192'({v, f, p});
  endfunction

  task automatic set_vec(input int i, input int a0, input int a1, input int a2, input int a3,
                         input int e0, input int e1, input int e2, input int e3);
    tbl[i].act[0] = DATA_W'(a0); tbl[i].act[1] = DATA_W'(a1);
    tbl[i].act[2] = DATA_W'(a2); tbl[i].act[3] = DATA_W'(a3);
    tbl[i].exp[0] = e0; tbl[i].exp[1] = e1; tbl[i].exp[2] = e2; tbl[i].exp[3] = e3;
  endtask

  task automatic load_row(input int w0, input int w1, input int w2, input int w3);
    w_v[0] = DATA_W'(w0); w_v[1] = DATA_W'(w1); w_v[2] = DATA_W'(w2); w_v[3] = DATA_W'(w3);
    bus.w_in = w_v; bus.w_load = 1'b1; bus.gate = 1'b1;
    tick();
    bus.w_load = 1'b0;
  endtask

  task automatic send(input logic [ROWS*DATA_W-1:0] a);
    bus.act_in = a; bus.act_valid = 1'b1; bus.gate = 1'b1;
    tick();
    bus.act_valid = 1'b0; bus.act_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  out_idx;
    logic g_now;

    rstn = 1'b0;
    bus.gate = 1'b0; bus.w_load = 1'b0; bus.w_in = '0; bus.act_in = '0; bus.act_valid = 1'b0;
    bus_s.gate = 1'b0; bus_s.w_load = 1'b0; bus_s.w_in = '0; bus_s.act_in = '0; bus_s.act_valid = 1'b0;

    // W[r][c]: row0 [1,-1,2,0] row1 [2,3,-1,1] row2 [-3,0,1,2] row3 [1,1,1,-2]
    set_vec(0,    1,   1,    1,   1,     1,    3,    3,    1);
    set_vec(1,    2,   0,    0,   0,     2,   -2,    4,    0);
    set_vec(2,    0,  -1,    2,   3,    -5,    0,    6,   -3);
    set_vec(3,  127, 127,  127, 127,   127,  381,  381,  127);
    set_vec(4, -128,-128, -128,-128,  -128, -384, -384, -128);
    set_vec(5,   10,  -5,    4,  -7,   -19,  -32,   22,   17);
    set_vec(6, -128, 127, -128, 127,   637,  636, -384, -383);
    set_vec(7,    3,  -2,   -1,   5,     7,   -4,   12,  -14);

    tick(); tick();
    check("reset_outputs", obs(), expv(1'b0, 4'h0, '0));
    check("reset_busy", 192'(bus.busy), 192'(1'b0));
    rstn = 1'b1;
    tick();

    // Identity weights: first row presented lands in row ROWS-1.
    load_row(0, 0, 0, 1);
    load_row(0, 0, 1, 0);
    load_row(0, 1, 0, 0);
    load_row(1, 0, 0, 0);
    a_v[0] = 8'sd1; a_v[1] = 8'sd2; a_v[2] = 8'sd3; a_v[3] = -8'sd4;
    e_ps[0] = 1; e_ps[1] = 2; e_ps[2] = 3; e_ps[3] = -4;
    send(a_v);
    check("busy_after_accept", 192'(bus.busy), 192'(1'b1));
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 7) check("ident_wait", obs(), expv(1'b0, 4'h0, '0));
      else       check("ident_out", obs(), expv(1'b1, 4'h0, e_ps));
    end
    bus.gate = 1'b0;
    tick(); tick();
    check("gate_hold_out", obs(), expv(1'b1, 4'h0, e_ps));
    bus.gate = 1'b1;
    tick();
    check("ident_clear", obs(), expv(1'b0, 4'h0, '0));
    check("ident_idle", 192'(bus.busy), 192'(1'b0));

    load_row(1, 1, 1, -2);
    load_row(-3, 0, 1, 2);
    load_row(2, 3, -1, 1);
    load_row(1, -1, 2, 0);

    // Stream 8 vectors with a 3-cycle stall after the third.
    out_idx = 0;
    for (int n = 0; n < 25; n++) begin
      if (n < 3) begin
        bus.gate = 1'b1; bus.act_valid = 1'b1; bus.act_in = tbl[n].act;
      end else if (n < 6) begin
        bus.gate = 1'b0; bus.act_valid = 1'b0; bus.act_in = '0;
      end else if (n < 11) begin
        bus.gate = 1'b1; bus.act_valid = 1'b1; bus.act_in = tbl[n-3].act;
      end else begin
        bus.gate = 1'b1; bus.act_valid = 1'b0; bus.act_in = '0;
      end
      g_now = bus.gate;
      tick();
      if (g_now && bus.psum_valid) begin
        if (out_idx < 8) begin
          check("stream_edge", 192'(n), 192'(10 + out_idx));
          check("stream_vec", obs(), expv(1'b1, 4'h0, tbl[out_idx].exp));
        end else begin
          check("stream_extra", obs(), expv(1'b0, 4'h0, '0));
        end
        out_idx++;
      end
      if (n == 16) check("stream_busy_last", 192'(bus.busy), 192'(1'b1));
      if (n == 17) check("stream_busy_drop", 192'(bus.busy), 192'(1'b0));
    end
    check("stream_count", 192'(out_idx), 192'(8));

    // Load requested while a vector is in flight must be ignored.
    send(tbl[0].act);
    for (int k = 1; k <= 6; k++) begin
      bus.w_load = 1'b1; bus.w_in = {4{8'sd5}};
      tick();
    end
    bus.w_load = 1'b0; bus.w_in = '0;
    tick();
    check("busy_load_inflight", obs(), expv(1'b1, 4'h0, tbl[0].exp));
    check("busy_load_idle", 192'(bus.busy), 192'(1'b0));
    send(tbl[0].act);
    for (int k = 1; k <= 7; k++) tick();
    check("busy_load_after", obs(), expv(1'b1, 4'h0, tbl[0].exp));

    // Idle load with act_valid: one-row shift wins, vector dropped, next vector uses it.
    w_v[0] = 8'sd4; w_v[1] = -8'sd2; w_v[2] = 8'sd0; w_v[3] = 8'sd1;
    bus.w_in = w_v; bus.w_load = 1'b1; bus.act_in = tbl[0].act; bus.act_valid = 1'b1;
    tick();
    bus.w_load = 1'b0; bus.act_valid = 1'b0;
    check("drop_no_busy", 192'(bus.busy), 192'(1'b0));
    send(tbl[0].act);
    e_ps[0] = 4; e_ps[1] = 0; e_ps[2] = 2; e_ps[3] = 4;
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (k < 8) check("drop_no_out", obs(), expv(1'b0, 4'h0, '0));
      else       check("load_to_use", obs(), expv(1'b1, 4'h0, e_ps));
    end

    // Reset with three vectors in flight.
    send(tbl[1].act); send(tbl[2].act); send(tbl[5].act);
    rstn = 1'b0;
    #1;
    check("rst_busy", 192'(bus.busy), 192'(1'b0));
    check("rst_outputs", obs(), expv(1'b0, 4'h0, '0));
    tick();
    rstn = 1'b1;
    send({4{8'sd5}});
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 7) check("rst_next_vec", obs(), expv(1'b1, 4'h0, '0));
      else        check("rst_no_stale", obs(), expv(1'b0, 4'h0, '0));
    end

    // 16-bit accumulator overflow: 4 * (127 * -128) = -65024.
    bus_s.gate = 1'b1; bus_s.w_load = 1'b1; bus_s.w_in = {4{8'sd127}};
    for (int k = 0; k < 4; k++) tick();
    bus_s.w_load = 1'b0;
    bus_s.act_in = {4{8'h80}}; bus_s.act_valid = 1'b1;
    tick();
    bus_s.act_valid = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
`ifdef PE_ARRAY_SAT_EN
    e_s = {4{16'h8000}};
`else
    e_s = {4{16'h0200}};
`endif
    check("overflow_vec", 192'({bus_s.psum_valid, bus_s.flag_overflow_O, bus_s.psum_out}),
          192'({1'b1, 4'hF, e_s}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
